w_fetch: RTL and testbench

//  Responder side of the weight-load handshake (w_read / clr_w -> w_done). On a clr_w

---
 rtl/w_fetch_if.sv | 27 ++
 rtl/w_fetch.sv | 96 +++++++++
 tb/tb_w_fetch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/w_fetch_if.sv
// w_fetch_if: weight-load handshake, SRAM read port and weight-buffer row stream for w_fetch.
interface w_fetch_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 12
);
    localparam int IW = $clog2(ROWS);
    logic                 i_w_read;
    logic                 i_clr_w;
    logic [AW-1:0]        i_base_addr;
    logic [COLS*DW-1:0]   i_mem_rdata;
    logic                 o_mem_rd_en;
    logic [AW-1:0]        o_mem_addr;
    logic                 o_w_row_valid;
    logic [COLS*DW-1:0]   o_w_row_data;
    logic [IW-1:0]        o_w_row_idx;
    logic                 o_w_done;
    modport slave (
        input  i_w_read, i_clr_w, i_base_addr, i_mem_rdata,
        output o_mem_rd_en, o_mem_addr, o_w_row_valid, o_w_row_data, o_w_row_idx, o_w_done
    );
    modport master (
        output i_w_read, i_clr_w, i_base_addr, i_mem_rdata,
        input  o_mem_rd_en, o_mem_addr, o_w_row_valid, o_w_row_data, o_w_row_idx, o_w_done
    );
endinterface

// File: rtl/w_fetch.sv
// w_fetch: fetches ROWS weight rows from SRAM on a clr_w request and streams them to the shadow weight buffer.
module w_fetch #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DW     = 8,
    parameter int AW     = 12,
    parameter int RD_LAT = 2
) (
    input logic      i_clk,
    input logic      i_rst_n,
    w_fetch_if.slave io_bus
);
    localparam int IW  = $clog2(ROWS);
    localparam int CW  = $clog2(ROWS + 1);
    localparam int DAT = COLS * DW;
    localparam logic [CW-1:0] NR = CW'(ROWS);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                    r_state;
    logic [AW-1:0]             r_base;
    logic [AW-1:0]             r_addr;
    logic [CW-1:0]             r_issued;
    logic [CW-1:0]             r_recvd;
    logic [RD_LAT-1:0]         r_pv;
    logic [RD_LAT-1:0][IW-1:0] r_pidx;
    logic                      r_rd_en;
    logic                      r_row_valid;
    logic [DAT-1:0]            r_row_data;
    logic [IW-1:0]             r_row_idx;
    logic                      r_done;

    logic w_restart;
    logic w_issue;
    logic w_head;

    assign w_restart = io_bus.i_w_read & io_bus.i_clr_w;
    assign w_issue   = (r_state == LOAD) & io_bus.i_w_read & (r_issued < NR);
    assign w_head    = r_pv[RD_LAT-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_addr      <= '0;
            r_issued    <= '0;
            r_recvd     <= '0;
            r_pv        <= '0;
            r_pidx      <= '0;
            r_rd_en     <= 1'b0;
            r_row_valid <= 1'b0;
            r_row_data  <= '0;
            r_row_idx   <= '0;
            r_done      <= 1'b0;
        end else if (w_restart) begin
            // the first read leaves with the restart itself; the pipe flush kills every older read
            r_state     <= LOAD;
            r_base      <= io_bus.i_base_addr;
            r_addr      <= io_bus.i_base_addr;
            r_rd_en     <= 1'b1;
            r_issued    <= CW'(1);
            r_recvd     <= '0;
            r_pv        <= '0;
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_addr   <= r_base + AW'(r_issued);
                r_issued <= r_issued + CW'(1);
            end
            r_pv[0]   <= r_rd_en;
            r_pidx[0] <= IW'(r_issued - CW'(1));
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_pv[k]   <= r_pv[k-1];
                r_pidx[k] <= r_pidx[k-1];
            end
            r_row_valid <= w_head;
            if (w_head) begin
                r_row_data <= io_bus.i_mem_rdata;
                r_row_idx  <= r_pidx[RD_LAT-1];
                r_recvd    <= r_recvd + CW'(1);
            end
            r_state <= (r_state == LOAD && r_issued == NR) ? DRAIN :
                       (r_state == DRAIN && r_recvd == NR) ? DONE : r_state;
            r_done  <= r_done | (r_state == DRAIN && r_recvd == NR);
        end
    end

    assign io_bus.o_mem_rd_en   = r_rd_en;
    assign io_bus.o_mem_addr    = r_addr;
    assign io_bus.o_w_row_valid = r_row_valid;
    assign io_bus.o_w_row_data  = r_row_data;
    assign io_bus.o_w_row_idx   = r_row_idx;
    assign io_bus.o_w_done      = r_done;
endmodule

// File: tb/tb_w_fetch.sv
// tb_w_fetch: scoreboard bench for w_fetch with an SRAM model and a load-level reference model.
module tb_w_fetch;
    localparam int ROWS = 4, COLS = 4, DW = 8, AW = 12, RD_LAT = 2;
    localparam int DAT = COLS * DW;
    localparam int IW  = $clog2(ROWS);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    w_fetch_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) bus ();

    w_fetch #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    logic [DAT-1:0] mem [4096];
    logic           sr_v [RD_LAT+1];
    logic [AW-1:0]  sr_a [RD_LAT+1];

    logic [AW-1:0]     exp_addr_q[$];
    logic [IW+DAT-1:0] exp_row_q[$];
    int rd_log[$], row_log[$], done_log[$];
    int n_vec = 0, n_err = 0;
    int cyc = 0, t0 = 0, rows_seen = 0, done_rises = 0;
    logic prev_wr = 1'b0, prev_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    always @(posedge clk) cyc++;

    // SRAM: data for a read appears RD_LAT cycles after its strobe, garbage otherwise
    always @(negedge clk) begin
        for (int k = RD_LAT; k > 0; k--) begin
            sr_v[k] = sr_v[k-1];
            sr_a[k] = sr_a[k-1];
        end
        sr_v[0] = bus.o_mem_rd_en;
        sr_a[0] = bus.o_mem_addr;
        bus.i_mem_rdata = sr_v[RD_LAT] ? mem[sr_a[RD_LAT]] : DAT'($urandom);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_mem_rd_en) begin
                rd_log.push_back(cyc - t0);
                chk("rd_expected", 64'(bus.o_mem_rd_en), 64'(exp_addr_q.size() > 0));
                chk("rd_gate", 64'(bus.o_mem_rd_en), 64'(prev_wr));
                if (exp_addr_q.size() > 0) chk("rd_addr", 64'(bus.o_mem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (bus.o_w_row_valid) begin
                row_log.push_back(cyc - t0);
                rows_seen++;
                chk("row_expected", 64'(bus.o_w_row_valid), 64'(exp_row_q.size() > 0));
                if (exp_row_q.size() > 0)
                    chk("row_idx_data", 64'({bus.o_w_row_idx, bus.o_w_row_data}), 64'(exp_row_q.pop_front()));
            end
            if (bus.o_w_done && !prev_done) begin
                done_log.push_back(cyc - t0);
                done_rises++;
                chk("done_rows_left", 64'(exp_row_q.size()), 64'(0));
            end
        end
        prev_wr   = bus.i_w_read;
        prev_done = bus.o_w_done;
    end

    task automatic flush();
        exp_addr_q.delete();
        exp_row_q.delete();
        rd_log.delete();
        row_log.delete();
        done_log.delete();
        rows_seen  = 0;
        done_rises = 0;
    endtask

    task automatic start_load(input logic [AW-1:0] b);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        bus.i_w_read    = 1'b1;
        bus.i_clr_w     = 1'b1;
        bus.i_base_addr = b;
        t0 = cyc;
        @(posedge clk);
        flush();
        for (int i = 0; i < ROWS; i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_row_q.push_back({IW'(i), mem[a]});
        end
        #1;
        bus.i_clr_w     = 1'b0;
        bus.i_base_addr = AW'($urandom);
        chk("restart_done_low", 64'(bus.o_w_done), 64'(0));
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!bus.o_w_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk({nm, "_done"}, 64'(bus.o_w_done), 64'(1));
        chk({nm, "_rows"}, 64'(rows_seen), 64'(ROWS));
        chk({nm, "_done_once"}, 64'(done_rises), 64'(1));
    endtask

    task automatic drive_rand(input int cycles, input bit stop_on_done);
        int k = 0;
        while (k < cycles && !(stop_on_done && bus.o_w_done)) begin
            @(posedge clk);
            #1;
            bus.i_w_read    = ($urandom_range(0, 3) != 0);
            bus.i_clr_w     = !bus.i_w_read && ($urandom_range(0, 1) != 0);
            bus.i_base_addr = AW'($urandom);
            k++;
        end
        bus.i_w_read = 1'b1;
        bus.i_clr_w  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DAT'($urandom);
        for (int k = 0; k <= RD_LAT; k++) begin
            sr_v[k] = 1'b0;
            sr_a[k] = '0;
        end
        bus.i_w_read    = 1'b0;
        bus.i_clr_w     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", 64'({bus.o_mem_rd_en, bus.o_mem_addr, bus.o_w_row_valid,
                                  bus.o_w_row_data, bus.o_w_row_idx, bus.o_w_done}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // basic load with exact cycle timing
        start_load(12'h100);
        wait_done("basic", 30);
        chk("basic_rd_count", 64'(rd_log.size()), 64'(ROWS));
        chk("basic_row_count", 64'(row_log.size()), 64'(ROWS));
        for (int i = 0; i < ROWS && i < rd_log.size(); i++) chk("basic_rd_cycle", 64'(rd_log[i]), 64'(i + 1));
        for (int i = 0; i < ROWS && i < row_log.size(); i++) chk("basic_row_cycle", 64'(row_log[i]), 64'(i + 4));
        if (done_log.size() > 0) chk("basic_done_cycle", 64'(done_log[0]), 64'(8));

        // done hold: w_read without clr_w is ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done", 64'(bus.o_w_done), 64'(1));
        end

        // pause after the second read
        start_load(12'h100);
        @(posedge clk);
        #1;
        bus.i_w_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.i_w_read = 1'b1;
        @(negedge clk);
        #1;
        chk("pause_reads", 64'(rd_log.size()), 64'(2));
        chk("pause_rows", 64'(rows_seen), 64'(2));
        wait_done("pause", 30);

        // address wrap
        start_load(12'hFFE);
        wait_done("wrap", 30);

        // abort with two reads in flight
        start_load(12'h100);
        start_load(12'h200);
        wait_done("abort", 30);
        if (done_log.size() > 0) chk("abort_done_cycle", 64'(done_log[0]), 64'(8));

        // async reset in DRAIN
        start_load(12'h340);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush();
        #1;
        chk("async_reset_outputs", 64'({bus.o_mem_rd_en, bus.o_mem_addr, bus.o_w_row_valid,
                                        bus.o_w_row_data, bus.o_w_row_idx, bus.o_w_done}), 64'(0));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("post_reset_rows", 64'(rows_seen), 64'(0));
        chk("post_reset_done", 64'(bus.o_w_done), 64'(0));

        // randomized loads, pauses, ignored clr_w and aborts
        for (int n = 0; n < 40; n++) begin
            start_load(AW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                drive_rand($urandom_range(0, 6), 1'b0);
                start_load(AW'($urandom));
            end
            drive_rand(80, 1'b1);
            wait_done("rand", 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
